// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared mode constants, total helper and delay-vector layout
package vga_timing_pkg;

    typedef struct packed {
        int unsigned visible;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } vga_axis_t;

    localparam vga_axis_t VGA_640X480_H = '{visible: 640, front: 16, sync: 96, back: 48};
    localparam vga_axis_t VGA_640X480_V = '{visible: 480, front: 10, sync: 2, back: 33};
    localparam int        VGA_640X480_H_POL = 0;
    localparam int        VGA_640X480_V_POL = 0;

    localparam vga_axis_t VGA_800X600_H = '{visible: 800, front: 40, sync: 128, back: 88};
    localparam vga_axis_t VGA_800X600_V = '{visible: 600, front: 1, sync: 4, back: 23};
    localparam int        VGA_800X600_H_POL = 1;
    localparam int        VGA_800X600_V_POL = 1;

    // Bit positions inside the vector carried by the latency-matching delay line
    localparam int DLY_ACTIVE = 0;
    localparam int DLY_VBLANK = 1;
    localparam int DLY_HBLANK = 2;
    localparam int DLY_VSYNC  = 3;
    localparam int DLY_HSYNC  = 4;
    localparam int DLY_W      = 5;

    function automatic int calc_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - renderer/pin-side signal bundle of the timing generator
interface vga_timing_gen_if #(
    parameter int p_CW = 10
);
    logic            i_Ce;
    logic            i_Video;
    logic [p_CW-1:0] o_X;
    logic [p_CW-1:0] o_Y;
    logic            o_Active;
    logic            o_HReset;
    logic            o_VReset;
    logic            o_HSync;
    logic            o_VSync;
    logic            o_HBlank;
    logic            o_VBlank;
    logic            o_Video;

    modport master (
        input  i_Ce, i_Video,
        output o_X, o_Y, o_Active, o_HReset, o_VReset,
        output o_HSync, o_VSync, o_HBlank, o_VBlank, o_Video
    );

    modport slave (
        output i_Ce, i_Video,
        input  o_X, o_Y, o_Active, o_HReset, o_VReset,
        input  o_HSync, o_VSync, o_HBlank, o_VBlank, o_Video
    );
endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - Ce-gated shift register with reset load value
module vga_delay_line #(
    parameter int                 p_WIDTH = 1,
    parameter int                 p_DEPTH = 1,
    parameter logic [p_WIDTH-1:0] p_INIT  = '0
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Ce,
    input  logic [p_WIDTH-1:0] i_Data,
    output logic [p_WIDTH-1:0] o_Data
);

    generate
        if (p_DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, i_Clk, i_Rst_n, i_Ce};
            assign o_Data      = i_Data;
        end else begin : g_shift
            logic [p_WIDTH-1:0] stage [p_DEPTH];

            always_ff @(posedge i_Clk or negedge i_Rst_n) begin
                if (!i_Rst_n) begin
                    for (int i = 0; i < p_DEPTH; i++) stage[i] <= p_INIT;
                end else if (i_Ce) begin
                    stage[0] <= i_Data;
                    for (int i = 1; i < p_DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign o_Data = stage[p_DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster counters, sync decode and latency matching
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int p_H_VISIBLE = 640,
    parameter int p_H_FRONT   = 16,
    parameter int p_H_SYNC    = 96,
    parameter int p_H_BACK    = 48,
    parameter int p_V_VISIBLE = 480,
    parameter int p_V_FRONT   = 10,
    parameter int p_V_SYNC    = 2,
    parameter int p_V_BACK    = 33,
    parameter int p_H_POL     = 0,
    parameter int p_V_POL     = 0,
    parameter int p_CW        = 10,
    parameter int p_LATENCY   = 2
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    vga_timing_gen_if.master  bus
);

    localparam int H_TOTAL = calc_total(p_H_VISIBLE, p_H_FRONT, p_H_SYNC, p_H_BACK);
    localparam int V_TOTAL = calc_total(p_V_VISIBLE, p_V_FRONT, p_V_SYNC, p_V_BACK);

    generate
        if (p_H_SYNC < 1 || p_V_SYNC < 1 || p_H_VISIBLE < 1 || p_V_VISIBLE < 1 ||
            p_LATENCY < 0 || p_LATENCY > 7 || p_CW < 1 ||
            H_TOTAL > (1 << p_CW) || V_TOTAL > (1 << p_CW)) begin : g_bad_params
            $error("vga_timing_gen: unsupported parameter combination");
        end
    endgenerate

    // Sync windows use inclusive last positions so a total of exactly 2**p_CW cannot wrap
    localparam logic [p_CW-1:0] H_LAST   = p_CW'(H_TOTAL - 1);
    localparam logic [p_CW-1:0] V_LAST   = p_CW'(V_TOTAL - 1);
    localparam logic [p_CW-1:0] H_VIS    = p_CW'(p_H_VISIBLE);
    localparam logic [p_CW-1:0] V_VIS    = p_CW'(p_V_VISIBLE);
    localparam logic [p_CW-1:0] HS_FIRST = p_CW'(p_H_VISIBLE + p_H_FRONT);
    localparam logic [p_CW-1:0] HS_LAST  = p_CW'(p_H_VISIBLE + p_H_FRONT + p_H_SYNC - 1);
    localparam logic [p_CW-1:0] VS_FIRST = p_CW'(p_V_VISIBLE + p_V_FRONT);
    localparam logic [p_CW-1:0] VS_LAST  = p_CW'(p_V_VISIBLE + p_V_FRONT + p_V_SYNC - 1);
    localparam logic            H_ON     = 1'(p_H_POL);
    localparam logic            V_ON     = 1'(p_V_POL);
    localparam logic [DLY_W-1:0] DLY_IDLE = {~H_ON, ~V_ON, 1'b1, 1'b1, 1'b0};

    logic [p_CW-1:0]  x_q;
    logic [p_CW-1:0]  y_q;
    logic             line_end;
    logic             hs_on;
    logic             vs_on;
    logic             active;
    logic [DLY_W-1:0] raw_vec;
    logic [DLY_W-1:0] dly_vec;

    assign line_end = (x_q == H_LAST);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (bus.i_Ce) begin
            if (line_end) begin
                x_q <= '0;
                y_q <= (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign hs_on  = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    assign vs_on  = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    assign active = (x_q < H_VIS) && (y_q < V_VIS);

    always_comb begin
        raw_vec             = '0;
        raw_vec[DLY_HSYNC]  = hs_on ? H_ON : ~H_ON;
        raw_vec[DLY_VSYNC]  = vs_on ? V_ON : ~V_ON;
        raw_vec[DLY_HBLANK] = (x_q >= H_VIS);
        raw_vec[DLY_VBLANK] = (y_q >= V_VIS);
        raw_vec[DLY_ACTIVE] = active;
    end

    vga_delay_line #(
        .p_WIDTH (DLY_W),
        .p_DEPTH (p_LATENCY),
        .p_INIT  (DLY_IDLE)
    ) u_delay (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Ce    (bus.i_Ce),
        .i_Data  (raw_vec),
        .o_Data  (dly_vec)
    );

    assign bus.o_X      = x_q;
    assign bus.o_Y      = y_q;
    assign bus.o_Active = active;
    assign bus.o_HReset = line_end;
    assign bus.o_VReset = line_end && (y_q == V_LAST);
    assign bus.o_HSync  = dly_vec[DLY_HSYNC];
    assign bus.o_VSync  = dly_vec[DLY_VSYNC];
    assign bus.o_HBlank = dly_vec[DLY_HBLANK];
    assign bus.o_VBlank = dly_vec[DLY_VBLANK];
    assign bus.o_Video  = dly_vec[DLY_ACTIVE] & bus.i_Video;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized check of three timing modes against a step-count model
module tb_vga_timing_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic ce    = 1'b0;
    logic vid   = 1'b0;
    longint n_step = 0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.p_CW(10)) if_a ();
    vga_timing_gen_if #(.p_CW(10)) if_b ();
    vga_timing_gen_if #(.p_CW(3))  if_c ();

    assign if_a.i_Ce = ce;  assign if_a.i_Video = vid;
    assign if_b.i_Ce = ce;  assign if_b.i_Video = vid;
    assign if_c.i_Ce = ce;  assign if_c.i_Video = vid;

    vga_timing_gen dut_a (.i_Clk(clk), .i_Rst_n(rst_n), .bus(if_a));

    vga_timing_gen #(
        .p_H_VISIBLE(20), .p_H_FRONT(2), .p_H_SYNC(3), .p_H_BACK(4),
        .p_V_VISIBLE(10), .p_V_FRONT(1), .p_V_SYNC(2), .p_V_BACK(3),
        .p_H_POL(0), .p_V_POL(1), .p_CW(10), .p_LATENCY(3)
    ) dut_b (.i_Clk(clk), .i_Rst_n(rst_n), .bus(if_b));

    vga_timing_gen #(
        .p_H_VISIBLE(4), .p_H_FRONT(1), .p_H_SYNC(1), .p_H_BACK(1),
        .p_V_VISIBLE(3), .p_V_FRONT(1), .p_V_SYNC(1), .p_V_BACK(1),
        .p_H_POL(1), .p_V_POL(0), .p_CW(3), .p_LATENCY(0)
    ) dut_c (.i_Clk(clk), .i_Rst_n(rst_n), .bus(if_c));

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d (step %0d, t=%0t)", tag, got, exp, n_step, $time);
        end
    endtask

    // Position after n pixel steps since reset is (n mod H_TOTAL, (n div H_TOTAL) mod V_TOTAL);
    // delayed outputs show position n-L, or the idle state while fewer than L steps exist.
    task automatic check_mode(input string nm, input int lat,
                              input int hv, input int hf, input int hsw, input int hbp,
                              input int vv, input int vf, input int vsw, input int vbp,
                              input bit hp, input bit vp,
                              input longint ox, input longint oy,
                              input logic oact, input logic ohr, input logic ovr,
                              input logic ohs, input logic ovs, input logic ohb,
                              input logic ovb, input logic ovid);
        int ht, vt, x, y, dx, dy;
        bit e_hs, e_vs, e_hb, e_vb, e_act;
        ht = hv + hf + hsw + hbp;
        vt = vv + vf + vsw + vbp;
        x  = int'(n_step % ht);
        y  = int'((n_step / ht) % vt);
        check({nm, ".x"}, ox, x);
        check({nm, ".y"}, oy, y);
        check({nm, ".active"}, oact, (x < hv && y < vv));
        check({nm, ".hreset"}, ohr, (x == ht - 1));
        check({nm, ".vreset"}, ovr, (x == ht - 1 && y == vt - 1));
        if (n_step < lat) begin
            e_hs = ~hp; e_vs = ~vp; e_hb = 1'b1; e_vb = 1'b1; e_act = 1'b0;
        end else begin
            dx = int'((n_step - lat) % ht);
            dy = int'(((n_step - lat) / ht) % vt);
            e_hs  = (dx >= hv + hf && dx < hv + hf + hsw) ? hp : ~hp;
            e_vs  = (dy >= vv + vf && dy < vv + vf + vsw) ? vp : ~vp;
            e_hb  = (dx >= hv);
            e_vb  = (dy >= vv);
            e_act = (dx < hv && dy < vv);
        end
        check({nm, ".hsync"}, ohs, e_hs);
        check({nm, ".vsync"}, ovs, e_vs);
        check({nm, ".hblank"}, ohb, e_hb);
        check({nm, ".vblank"}, ovb, e_vb);
        check({nm, ".video"}, ovid, e_act & vid);
    endtask

    task automatic check_all();
        check_mode("a", 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                   if_a.o_X, if_a.o_Y, if_a.o_Active, if_a.o_HReset, if_a.o_VReset,
                   if_a.o_HSync, if_a.o_VSync, if_a.o_HBlank, if_a.o_VBlank, if_a.o_Video);
        check_mode("b", 3, 20, 2, 3, 4, 10, 1, 2, 3, 1'b0, 1'b1,
                   if_b.o_X, if_b.o_Y, if_b.o_Active, if_b.o_HReset, if_b.o_VReset,
                   if_b.o_HSync, if_b.o_VSync, if_b.o_HBlank, if_b.o_VBlank, if_b.o_Video);
        check_mode("c", 0, 4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b0,
                   if_c.o_X, if_c.o_Y, if_c.o_Active, if_c.o_HReset, if_c.o_VReset,
                   if_c.o_HSync, if_c.o_VSync, if_c.o_HBlank, if_c.o_VBlank, if_c.o_Video);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        n_step = 0;
        for (int c = 0; c < 5000; c++) begin
            // Phases: reset with toggling Ce, free-running Ce, every-other Ce, random Ce
            if (c < 10 || (c >= 4001 && c < 4004)) rst_n = 1'b0;
            else rst_n = 1'b1;
            if (c < 10)        ce = c[0];
            else if (c < 2000) ce = 1'b1;
            else if (c < 3000) ce = c[0];
            else               ce = ($urandom_range(0, 3) != 0);
            vid = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (!rst_n) n_step = 0;
            else if (ce) n_step++;
            if (c == 4000) begin
                #2 rst_n = 1'b0;
                n_step = 0;
                #1 check_all();
            end
            @(negedge clk);
            check_all();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, successor to the fixed 640x480 generator. Every porch, sync width and polarity is configurable, and the counters advance on a pixel clock-enable, so one fast system clock can drive any mode. It exports 0-based pixel coordinates to the renderer and delays sync, blank and active by a programmable pipeline latency so that they line up with the renderer's returned video. It sits between the game renderer and the DAC/pins.

Parameters:
p_H_VISIBLE, 640, visible pixels per line
p_H_FRONT, 16, horizontal front porch (pixels)
p_H_SYNC, 96, horizontal sync width (pixels)
p_H_BACK, 48, horizontal back porch (pixels)
p_V_VISIBLE, 480, visible lines per frame
p_V_FRONT, 10, vertical front porch (lines)
p_V_SYNC, 2, vertical sync width (lines)
p_V_BACK, 33, vertical back porch (lines)
p_H_POL, 0, active level of HSync (0 = active-low)
p_V_POL, 0, active level of VSync
p_CW, 10, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
p_LATENCY, 2, renderer latency in Ce-steps, range 0..7

Ports:
i_Clk  in  1  system clock; all state changes on its rising edge
i_Rst_n  in  1  asynchronous, active-low reset
i_Ce  in  1  pixel clock-enable; counters and delay lines advance only when it is 1
i_Video  in  1  renderer pixel, valid p_LATENCY Ce-steps after o_X/o_Y
o_X  out  p_CW  current column, 0..H_TOTAL-1 (undelayed)
o_Y  out  p_CW  current line, 0..V_TOTAL-1 (undelayed)
o_Active  out  1  undelayed: high when X<H_VISIBLE && Y<V_VISIBLE
o_HReset  out  1  undelayed: high while X==H_TOTAL-1
o_VReset  out  1  undelayed: high while X==H_TOTAL-1 && Y==V_TOTAL-1
o_HSync  out  1  delayed horizontal sync, polarity set by p_H_POL
o_VSync  out  1  delayed vertical sync, polarity set by p_V_POL
o_HBlank  out  1  delayed: high when X>=H_VISIBLE
o_VBlank  out  1  delayed: high when Y>=V_VISIBLE
o_Video  out  1  delayed active AND i_Video

Behaviour:
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is defined the same way. All arithmetic is unsigned p_CW bits.
- Counters are registered. On a rising edge with i_Ce=1:
  - X wraps to 0 when X==H_TOTAL-1, otherwise X increments.
  - Y advances only when X==H_TOTAL-1; it wraps to 0 when Y==V_TOTAL-1.
- With i_Ce=0 every register holds its value.
- Raw sync decode:
  - HSync is asserted for X in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC).
  - VSync is asserted for Y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC) for the whole line, with no pixel offset.
  - The asserted level is p_*_POL; the idle level is its inverse.
- Delay pipeline:
  - The raw {hsync, vsync, hblank, vblank, active} vector passes through a p_LATENCY-deep shift register that shifts only on i_Ce.
  - With p_LATENCY=0 the delayed outputs are a direct combinational decode of the counters.
  - The delayed outputs at Ce-step n always reflect counter position n-p_LATENCY.
- o_Video = delayed_active & i_Video. i_Video is ignored whenever delayed_active is 0.
- o_HReset and o_VReset are level decodes held for the full Ce-period of that pixel. They are not narrowed to a single i_Clk cycle.
- Reset, asynchronous assert:
  - X=0, Y=0.
  - Every delay stage is loaded with the idle state: sync idle level, blank=1, active=0.
  - Resulting outputs: o_HSync=~p_H_POL, o_VSync=~p_V_POL, o_HBlank=1, o_VBlank=1, o_Video=0. The undelayed outputs follow from X=Y=0: o_Active=1 and o_HReset=o_VReset=0.
- Reset release: counting resumes on the first rising edge where i_Rst_n=1 and i_Ce=1.
- Reset mid-frame: same as reset from power-up. There are no partial-line artefacts; after release, the first line is line 0 pixel 0.
- Zero porch widths are legal. H_SYNC and V_SYNC must be at least 1. Unsupported parameter combinations are flagged by an elaboration-time check.

Decomposition:
- Package vga_timing_pkg holds:
  - mode constant sets (640x480@60, 800x600@60) as localparams;
  - a function computing totals;
  - the delay-vector field indices.
- Sub-module vga_delay_line(p_WIDTH, p_DEPTH) is a Ce-gated shift register with an async-reset load value; depth 0 is a pass-through.

Test Plan:
- Reset: hold i_Rst_n=0 with default params and i_Ce toggling → X=0, Y=0, o_HSync=1, o_VSync=1, o_HBlank=1, o_VBlank=1, o_Video=0.
- Full frame, defaults, i_Ce=1, p_LATENCY=0:
  - o_HSync is low for exactly 96 cycles starting at X=656.
  - o_VReset is high once per 420000 cycles.
  - o_VSync is low during lines 490-491.
- Ce gating, i_Ce high every 2nd cycle → all periods double. X holds its value on cycles where i_Ce=0.
- Latency, p_LATENCY=3, i_Video = (X==5 delayed 3 Ce-steps):
  - o_Video pulses exactly one pixel, coinciding with the 6th delayed-active pixel.
  - o_HBlank rises exactly 3 Ce-steps after X reaches 640.
- Tiny mode, H=4/1/1/1, V=3/1/1/1, p_H_POL=1:
  - X runs 0..6 and Y runs 0..5.
  - HSync is high only at X=5.
  - Y wraps after X=6, Y=5.
- Async reset asserted mid-line at X=300, Y=200, between clock edges → outputs go idle immediately without a clock edge; after release, X counts 0,1,2...
